sha1_match_collector: RTL and testbench

SHA1_MATCH_COLLECTOR -- requirements
Module: sha1_match_collector

---
 rtl/sha1_match_collector_if.sv | 21 ++
 rtl/sha1_match_collector.sv | 164 ++++++++++++++++
 tb/tb_sha1_match_collector.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_match_collector_if.sv
// Byte-stream interface carrying serialized match records out of the collector.
interface sha1_match_collector_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sha1_match_collector.sv
// Collects matching {nonce, context} results from a SHA-1 nonce search into a
// small FIFO and streams each one out as a byte record, nonce first.
module sha1_match_collector #(
  parameter int NONCE_SIZE = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  hash_i,
  input  logic                  match_i,
  input  logic                  search_done_i,
  input  logic [NONCE_SIZE-1:0] nonce_i,
  input  logic [159:0]          context_i,
  sha1_match_collector_if.master out_if,
  output logic [31:0]           hash_count_o,
  output logic [15:0]           match_count_o,
  output logic                  overflow_o,
  output logic                  finished_o
);

  localparam int ENTRY_W      = NONCE_SIZE + 160;
  localparam int RECORD_BYTES = NONCE_SIZE / 8 + 20;
  localparam int AW           = $clog2(DEPTH);
  localparam int PW           = AW + 1;
  localparam int CW           = $clog2(RECORD_BYTES);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]  shift_q, shift_d;
  logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]         hash_count_q, hash_count_d;
  logic [15:0]         match_count_q, match_count_d;
  logic                overflow_q, overflow_d;

  logic fifo_empty;
  logic fifo_full;
  logic capture;
  logic push;
  logic pop;
  logic drop;
  logic last_byte;

  // A full FIFO still accepts a capture when the serializer frees the head slot in the same cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    capture    = hash_i & match_i & ~start_i;
    pop        = (state_q == IDLE) & ~fifo_empty & ~start_i;
    push       = capture & (~fifo_full | pop);
    drop       = capture & ~push;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    hash_count_d  = hash_count_q;
    match_count_d = match_count_q;
    overflow_d    = overflow_q;
    if (start_i) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      hash_count_d  = '0;
      match_count_d = '0;
      overflow_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (hash_i && (hash_count_q != 32'hFFFF_FFFF)) begin
        hash_count_d = hash_count_q + 32'd1;
      end
      if (capture && (match_count_q != 16'hFFFF)) begin
        match_count_d = match_count_q + 16'd1;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Serializer: the head entry is copied into a shift register so the FIFO slot frees immediately.
  always_comb begin
    state_d          = state_q;
    shift_d          = shift_q;
    byte_cnt_d       = byte_cnt_q;
    out_if.out_valid = 1'b0;
    out_if.out_last  = 1'b0;
    last_byte        = (byte_cnt_q == CW'(RECORD_BYTES - 1));
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d    = SEND;
          shift_d    = mem_q[rd_ptr_q[AW-1:0]];
          byte_cnt_d = '0;
        end
      end
      SEND: begin
        out_if.out_valid = 1'b1;
        out_if.out_last  = last_byte;
        if (out_if.out_ready) begin
          shift_d    = shift_q << 8;
          byte_cnt_d = byte_cnt_q + CW'(1);
          if (last_byte) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (start_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      hash_count_q  <= '0;
      match_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      shift_q       <= shift_d;
      byte_cnt_q    <= byte_cnt_d;
      hash_count_q  <= hash_count_d;
      match_count_q <= match_count_d;
      overflow_q    <= overflow_d;
    end
  end

  // Storage carries no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {nonce_i, context_i};
    end
  end

  assign out_if.out_data = shift_q[ENTRY_W-1 -: 8];
  assign hash_count_o    = hash_count_q;
  assign match_count_o   = match_count_q;
  assign overflow_o      = overflow_q;
  assign finished_o      = search_done_i & fifo_empty & (state_q == IDLE);

endmodule

// File: tb/tb_sha1_match_collector.sv
// Scoreboard bench for sha1_match_collector: expected record bytes are queued at
// capture time and a negedge monitor pops and compares every accepted byte.
module tb_sha1_match_collector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         hash = 1'b0;
  logic         match = 1'b0;
  logic         searchDone = 1'b0;
  logic [15:0]  nonce = '0;
  logic [159:0] ctx = '0;
  logic [31:0]  hashCount;
  logic [15:0]  matchCount;
  logic         overflow;
  logic         finished;

  int checkCount = 0;
  int passCount  = 0;

  logic [8:0] expQ [$];
  logic [8:0] expByte;
  bit         stalled = 1'b0;
  logic [7:0] stallData;
  logic       stallLast;

  localparam logic [159:0] CTX_1 = 160'h0123456789ABCDEF0123456789ABCDEF01234567;
  localparam logic [159:0] CTX_A = 160'hDEADBEEF_00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [159:0] CTX_B = 160'hFEDCBA98_76543210_A5A5A5A5_5A5A5A5A_0F1E2D3C;
  localparam logic [159:0] CTX_C = 160'h11111111_22222222_33333333_44444444_55555555;

  // Hand-computed byte stream for nonce 0x1234 with CTX_1.
  logic [7:0] singleBytes [22] = '{
    8'h12, 8'h34, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01,
    8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67
  };

  sha1_match_collector_if sIf ();

  sha1_match_collector #(
    .NONCE_SIZE(16),
    .DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .hash_i       (hash),
    .match_i      (match),
    .search_done_i(searchDone),
    .nonce_i      (nonce),
    .context_i    (ctx),
    .out_if       (sIf),
    .hash_count_o (hashCount),
    .match_count_o(matchCount),
    .overflow_o   (overflow),
    .finished_o   (finished)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushRecord(input logic [15:0] n, input logic [159:0] c);
    logic [175:0] rec;
    rec = {n, c};
    for (int i = 0; i < 22; i++) begin
      expQ.push_back({(i == 21), rec[175 - 8*i -: 8]});
    end
  endtask

  task automatic applyStimulus(input logic h, input logic m, input logic [15:0] n,
                               input logic [159:0] c, input bit expectRecord);
    hash  = h;
    match = m;
    nonce = n;
    ctx   = c;
    if (expectRecord) begin
      pushRecord(n, c);
    end
    tick();
    hash  = 1'b0;
    match = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int i;
    i = 0;
    while (!sIf.out_valid && i < 20) begin
      tick();
      i++;
    end
    checkOutput(name, 32'(sIf.out_valid), 32'd1);
  endtask

  task automatic waitDrain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (expQ.size() == 0 && !sIf.out_valid) break;
      tick();
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: compares every accepted byte against the queue and checks hold-stability while stalled.
  always @(negedge clk) begin
    if (rst_n && sIf.out_valid) begin
      if (stalled) begin
        checkOutput("stable_data", 32'(sIf.out_data), 32'(stallData));
        checkOutput("stable_last", 32'(sIf.out_last), 32'(stallLast));
      end
      if (sIf.out_ready) begin
        stalled = 1'b0;
        if (expQ.size() == 0) begin
          checkCount++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", sIf.out_data);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("byte_data", 32'(sIf.out_data), 32'(expByte[7:0]));
          checkOutput("byte_last", 32'(sIf.out_last), 32'(expByte[8]));
        end
      end else begin
        stalled   = 1'b1;
        stallData = sIf.out_data;
        stallLast = sIf.out_last;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    sIf.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid",    32'(sIf.out_valid), 32'd0);
    checkOutput("rst_last",     32'(sIf.out_last),  32'd0);
    checkOutput("rst_data",     32'(sIf.out_data),  32'd0);
    checkOutput("rst_hash",     hashCount,          32'd0);
    checkOutput("rst_match",    32'(matchCount),    32'd0);
    checkOutput("rst_overflow", 32'(overflow),      32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Single match, literal byte stream
    $display("[TB] single match");
    pulseStart();
    sIf.out_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      expQ.push_back({(i == 21), singleBytes[i]});
    end
    applyStimulus(1'b1, 1'b1, 16'h1234, CTX_1, 1'b0);
    waitDrain("single_drain", 60);
    checkOutput("single_match_count", 32'(matchCount), 32'd1);
    checkOutput("single_hash_count",  hashCount,       32'd1);

    // Backpressure: out_ready toggles every cycle
    $display("[TB] backpressure");
    pulseStart();
    sIf.out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'hBEEF, CTX_B, 1'b1);
    for (int i = 0; i < 120; i++) begin
      if (expQ.size() == 0 && !sIf.out_valid) break;
      sIf.out_ready = ~sIf.out_ready;
      tick();
    end
    checkOutput("bp_drain", 32'(expQ.size()), 32'd0);

    // Overflow: a blocker record occupies the serializer, then nonces 1..5 hit a 4-deep FIFO
    $display("[TB] overflow");
    sIf.out_ready = 1'b0;
    pulseStart();
    applyStimulus(1'b1, 1'b1, 16'h00FF, CTX_A, 1'b1);
    waitValid("ovf_blocker_valid");
    for (int n = 1; n <= 5; n++) begin
      applyStimulus(1'b1, 1'b1, 16'(n), CTX_C, (n <= 4));
    end
    checkOutput("ovf_overflow",    32'(overflow),   32'd1);
    checkOutput("ovf_match_count", 32'(matchCount), 32'd6);
    checkOutput("ovf_hash_count",  hashCount,       32'd6);
    sIf.out_ready = 1'b1;
    waitDrain("ovf_drain", 300);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    pulseStart();
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);

    // Counters: 1000 hashes with 3 matches, plus ignored match-without-hash
    $display("[TB] counters");
    pulseStart();
    sIf.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic m;
      m = (i == 100) || (i == 400) || (i == 800);
      applyStimulus(1'b1, m, 16'(i), CTX_A, m);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hAAAA, CTX_B, 1'b0);
    end
    waitDrain("cnt_drain", 60);
    checkOutput("cnt_hash",  hashCount,       32'd1000);
    checkOutput("cnt_match", 32'(matchCount), 32'd3);
    pulseStart();
    checkOutput("cnt_hash_clear",  hashCount,       32'd0);
    checkOutput("cnt_match_clear", 32'(matchCount), 32'd0);

    // Start mid-record after five accepted bytes
    $display("[TB] start mid-record");
    sIf.out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'hC0DE, CTX_B, 1'b1);
    waitValid("midstart_valid");
    sIf.out_ready = 1'b1;
    repeat (5) tick();
    sIf.out_ready = 1'b0;
    start = 1'b1;
    expQ.delete();
    tick();
    start = 1'b0;
    checkOutput("midstart_out_valid", 32'(sIf.out_valid), 32'd0);
    searchDone = 1'b1;
    #1;
    checkOutput("midstart_finished", 32'(finished), 32'd1);
    sIf.out_ready = 1'b1;
    repeat (10) tick();
    searchDone = 1'b0;

    // Async reset mid-record, then finished after a clean drain
    $display("[TB] async reset");
    pulseStart();
    searchDone    = 1'b1;
    sIf.out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h5A5A, CTX_C, 1'b1);
    checkOutput("rstmid_not_finished", 32'(finished), 32'd0);
    waitValid("rstmid_valid");
    sIf.out_ready = 1'b1;
    repeat (3) tick();
    sIf.out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rstmid_out_valid", 32'(sIf.out_valid), 32'd0);
    checkOutput("rstmid_out_last",  32'(sIf.out_last),  32'd0);
    checkOutput("rstmid_out_data",  32'(sIf.out_data),  32'd0);
    checkOutput("rstmid_hash",      hashCount,          32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    checkOutput("rstmid_finished", 32'(finished), 32'd1);
    sIf.out_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0F0F, CTX_A, 1'b1);
    checkOutput("fin_pending", 32'(finished), 32'd0);
    waitDrain("fin_drain", 60);
    checkOutput("fin_done", 32'(finished), 32'd1);
    searchDone = 1'b0;

    repeat (3) tick();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
